// File: rtl/nn_layer_sequencer_pkg.sv
// Shared sizes, FSM state type and helpers for the two-layer NN sequencer.
// Package name: nn_parameters.
package nn_parameters;

    // Default layer geometry (overridable per instance).
    localparam int IN_SIZE_1  = 4;
    localparam int OUT_SIZE_1 = 4;
    localparam int IN_SIZE_2  = 4;
    localparam int OUT_SIZE_2 = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MAC,
        S_WR,
        S_DONE
    } seq_state_e;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/nn_layer_sequencer_idx_counter.sv
// nn_idx_counter: up-counter with load-to-zero, enable and a terminal-count
// flag; it refuses to step past last_i so it can never address unused rows.
module nn_idx_counter
    import nn_parameters::*;
#(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;

    assign tc_o  = (cnt_q == last_i);
    assign cnt_o = cnt_q;

    // Next count: load wins over enable; hold at terminal count.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (en_i && !tc_o)
            cnt_d = cnt_q + 1'b1;
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer: drives a shared MAC datapath through two dense layers
// (bias load, Lx_IN MACs, ReLU write per neuron). Optional busy-cycle
// performance counter enabled by macro NN_SEQ_PERF_CNT_EN.
module nn_layer_sequencer
    import nn_parameters::*;
#(
    parameter int L1_IN  = IN_SIZE_1,
    parameter int L1_OUT = OUT_SIZE_1,
    parameter int L2_IN  = IN_SIZE_2,
    parameter int L2_OUT = OUT_SIZE_2,
    parameter int IDX_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             layer_sel,
    output logic [IDX_W-1:0] in_idx,
    output logic [IDX_W-1:0] out_idx,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             out_wr,
    output logic [15:0]      cycle_cnt
);

    localparam logic [IDX_W-1:0] L1_IN_LAST  = IDX_W'(L1_IN - 1);
    localparam logic [IDX_W-1:0] L1_OUT_LAST = IDX_W'(L1_OUT - 1);
    localparam logic [IDX_W-1:0] L2_IN_LAST  = IDX_W'(L2_IN - 1);
    localparam logic [IDX_W-1:0] L2_OUT_LAST = IDX_W'(L2_OUT - 1);

    seq_state_e state_q;
    logic       busy_q, done_q, layer_sel_q;
    logic       acc_clr_q, acc_en_q, out_wr_q;

    logic             in_load, in_en, in_tc;
    logic             out_load, out_en, out_tc;
    logic [IDX_W-1:0] in_last, out_last;
    logic             kill;
    logic             accept;

    assign kill   = abort && (state_q != S_IDLE);
    assign accept = (state_q == S_IDLE) && start && !abort;

    assign in_last  = layer_sel_q ? L2_IN_LAST  : L1_IN_LAST;
    assign out_last = layer_sel_q ? L2_OUT_LAST : L1_OUT_LAST;

    // in_idx walks only during MAC and is parked at 0 everywhere else.
    assign in_load = kill || (state_q != S_MAC);
    assign in_en   = (state_q == S_MAC);

    // out_idx steps after each write; it restarts at the layer switch and on exit.
    assign out_load = kill || (state_q == S_IDLE) || (state_q == S_DONE) ||
                      ((state_q == S_WR) && out_tc && !layer_sel_q);
    assign out_en   = (state_q == S_WR) && !out_tc;

    nn_idx_counter #(.IDX_W(IDX_W)) u_in_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (in_load),
        .en_i   (in_en),
        .last_i (in_last),
        .cnt_o  (in_idx),
        .tc_o   (in_tc)
    );

    nn_idx_counter #(.IDX_W(IDX_W)) u_out_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (out_load),
        .en_i   (out_en),
        .last_i (out_last),
        .cnt_o  (out_idx),
        .tc_o   (out_tc)
    );

    // Sequencer FSM; strobes are computed for the state being entered so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            layer_sel_q <= 1'b0;
            acc_clr_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            out_wr_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            acc_clr_q <= 1'b0;
            acc_en_q  <= 1'b0;
            out_wr_q  <= 1'b0;
            if (kill) begin
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
                layer_sel_q <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (accept) begin
                            state_q     <= S_CLR;
                            busy_q      <= 1'b1;
                            layer_sel_q <= 1'b0;
                            acc_clr_q   <= 1'b1;
                        end
                    end
                    S_CLR: begin
                        state_q  <= S_MAC;
                        acc_en_q <= 1'b1;
                    end
                    S_MAC: begin
                        if (in_tc) begin
                            state_q  <= S_WR;
                            out_wr_q <= 1'b1;
                        end else begin
                            acc_en_q <= 1'b1;
                        end
                    end
                    S_WR: begin
                        if (out_tc && layer_sel_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            if (out_tc)
                                layer_sel_q <= 1'b1;
                            state_q   <= S_CLR;
                            acc_clr_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q     <= S_IDLE;
                        busy_q      <= 1'b0;
                        layer_sel_q <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign layer_sel = layer_sel_q;
    assign acc_clr   = acc_clr_q;
    assign acc_en    = acc_en_q;
    assign out_wr    = out_wr_q;

`ifdef NN_SEQ_PERF_CNT_EN
    logic [15:0] perf_q;
    logic [15:0] cycle_cnt_q;

    // Busy-cycle counter; the DONE cycle itself is included in the published value.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q      <= '0;
            cycle_cnt_q <= '0;
        end else begin
            if (accept)
                perf_q <= '0;
            else if (state_q != S_IDLE)
                perf_q <= sat_inc16(perf_q);
            if ((state_q == S_DONE) && !abort)
                cycle_cnt_q <= sat_inc16(perf_q);
        end
    end

    assign cycle_cnt = cycle_cnt_q;
`else
    assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer with L1_IN=3, L1_OUT=2, L2_IN=2, L2_OUT=2.
module tb_nn_layer_sequencer;

    localparam int IDX_W = 8;
`ifdef NN_SEQ_PERF_CNT_EN
    localparam logic [15:0] EXP_CNT = 16'd19;
`else
    localparam logic [15:0] EXP_CNT = 16'd0;
`endif

    logic             clk = 1'b0;
    logic             rst, start, abort;
    logic             busy, done, layer_sel, acc_clr, acc_en, out_wr;
    logic [IDX_W-1:0] in_idx, out_idx;
    logic [15:0]      cycle_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nn_layer_sequencer #(
        .L1_IN(3), .L1_OUT(2), .L2_IN(2), .L2_OUT(2), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .layer_sel(layer_sel),
        .in_idx(in_idx), .out_idx(out_idx),
        .acc_clr(acc_clr), .acc_en(acc_en), .out_wr(out_wr),
        .cycle_cnt(cycle_cnt)
    );

    typedef struct packed {
        logic       start;
        logic       abort;
        logic       busy;
        logic       done;
        logic       ls;
        logic       clr;
        logic       en;
        logic       wr;
        logic [7:0] in_i;
        logic [7:0] out_i;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic s, input logic b, input logic d,
                                input logic ls, input logic c, input logic e,
                                input logic w, input int ii, input int oi);
        vec_t v;
        v.start = s;   v.abort = 1'b0;
        v.busy  = b;   v.done  = d;   v.ls = ls;
        v.clr   = c;   v.en    = e;   v.wr = w;
        v.in_i  = 8'(ii);
        v.out_i = 8'(oi);
        return v;
    endfunction

    function automatic logic [21:0] obs();
        return {busy, done, layer_sel, acc_clr, acc_en, out_wr, in_idx, out_idx};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_clr, n_en, n_wr, n_done, lat;
        logic seen;

        // Per-cycle trace of one full run; record i holds inputs of cycle i, outputs of cycle i+1.
        //             st b  d  ls c  e  w  in out
        tbl[0]  = mk(1, 1, 0, 0, 1, 0, 0, 0, 0);  // CLR  n0
        tbl[1]  = mk(0, 1, 0, 0, 0, 1, 0, 0, 0);  // MAC
        tbl[2]  = mk(0, 1, 0, 0, 0, 1, 0, 1, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 1, 0, 2, 0);
        tbl[4]  = mk(0, 1, 0, 0, 0, 0, 1, 2, 0);  // WR   (0,0)
        tbl[5]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 1);  // CLR  n1
        tbl[6]  = mk(0, 1, 0, 0, 0, 1, 0, 0, 1);
        tbl[7]  = mk(0, 1, 0, 0, 0, 1, 0, 1, 1);
        tbl[8]  = mk(0, 1, 0, 0, 0, 1, 0, 2, 1);
        tbl[9]  = mk(0, 1, 0, 0, 0, 0, 1, 2, 1);  // WR   (1,0)
        tbl[10] = mk(0, 1, 0, 1, 1, 0, 0, 0, 0);  // CLR  layer 2 n0
        tbl[11] = mk(0, 1, 0, 1, 0, 1, 0, 0, 0);
        tbl[12] = mk(0, 1, 0, 1, 0, 1, 0, 1, 0);
        tbl[13] = mk(0, 1, 0, 1, 0, 0, 1, 1, 0);  // WR   (0,1)
        tbl[14] = mk(0, 1, 0, 1, 1, 0, 0, 0, 1);  // CLR  layer 2 n1
        tbl[15] = mk(0, 1, 0, 1, 0, 1, 0, 0, 1);
        tbl[16] = mk(0, 1, 0, 1, 0, 1, 0, 1, 1);
        tbl[17] = mk(0, 1, 0, 1, 0, 0, 1, 1, 1);  // WR   (1,1)
        tbl[18] = mk(0, 1, 1, 1, 0, 0, 0, 0, 1);  // DONE (cycle 19)
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);  // back to IDLE

        // Reset state.
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        tick(); tick();
        check("reset_outputs", 32'(obs()), 32'd0);
        check("reset_cycle_cnt", 32'(cycle_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Full run from the vector table.
        n_clr = 0; n_en = 0; n_wr = 0;
        for (int i = 0; i < 20; i++) begin
            start = tbl[i].start;
            abort = tbl[i].abort;
            tick();
            check($sformatf("run_cycle_%0d", i + 1), 32'(obs()),
                  32'({tbl[i].busy, tbl[i].done, tbl[i].ls, tbl[i].clr,
                       tbl[i].en, tbl[i].wr, tbl[i].in_i, tbl[i].out_i}));
            n_clr += int'(acc_clr);
            n_en  += int'(acc_en);
            n_wr  += int'(out_wr);
        end
        check("acc_clr_pulses", 32'(n_clr), 32'd4);
        check("acc_en_pulses", 32'(n_en), 32'd10);
        check("out_wr_pulses", 32'(n_wr), 32'd4);
        check("cycle_cnt_after_run", 32'(cycle_cnt), 32'(EXP_CNT));

        // abort and start together in IDLE: abort wins.
        start = 1'b1; abort = 1'b1;
        tick();
        check("abort_beats_start", 32'(busy), 32'd0);
        start = 1'b0; abort = 1'b0;
        tick();

        // start held high: exactly one done, re-accept only after IDLE.
        start = 1'b1;
        tick();                          // cycle 1
        n_done = int'(done);
        for (int c = 2; c <= 20; c++) begin
            tick();
            n_done += int'(done);
        end
        check("held_start_single_done", 32'(n_done), 32'd1);
        check("held_start_idle_c20", 32'(busy), 32'd0);
        tick();                          // cycle 21: second run accepted at cycle 20
        check("held_start_reaccept", 32'({busy, acc_clr}), 32'h3);
        start = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_from_clr", 32'(obs()), 32'd0);
        tick();

        // abort in cycle 7 of a run.
        start = 1'b1;
        tick();                          // cycle 1
        start = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        abort = 1'b1;
        tick();                          // cycle 8
        abort = 1'b0;
        check("abort_c7_idle", 32'(obs()), 32'd0);
        n_done = 0; n_wr = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            n_done += int'(done);
            n_wr   += int'(out_wr);
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_no_out_wr", 32'(n_wr), 32'd0);
        check("abort_cycle_cnt_kept", 32'(cycle_cnt), 32'(EXP_CNT));

        // rst in MAC, then a full run with bounded wait for done.
        start = 1'b1;
        tick();                          // cycle 1 CLR
        start = 1'b0;
        tick(); tick();                  // cycle 3 MAC
        check("pre_rst_in_mac", 32'({acc_en, in_idx}), 32'h101);
        rst = 1'b1;
        tick();
        check("rst_mid_outputs", 32'(obs()), 32'd0);
        check("rst_mid_cycle_cnt", 32'(cycle_cnt), 32'd0);
        rst = 1'b0;
        start = 1'b1;
        tick();                          // accepted, cycle 1
        start = 1'b0;
        lat = 1; seen = 1'b0;
        while (!seen && lat < 60) begin
            tick();
            lat++;
            seen = done;
        end
        check("post_rst_latency", 32'(lat), 32'd19);
        tick();
        check("post_rst_cycle_cnt", 32'(cycle_cnt), 32'(EXP_CNT));
        check("post_rst_idle", 32'(obs()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
